simple_proc_prog_mem: RTL and testbench
=======================================

// Module: simple_proc_prog_mem
// PURPOSE
//  Program-memory responder on the fetch side of simple_proc_data_proc. Host streams a program in
//  over a valid/ready port; block stores it, pulses start, then answers every processor fetch
//  (pc + ram_read_en) with the stored word on data_out/data_vld one cycle later.
// PARAMETERS
//  DEPTH     1024     program words stored; pc width is fixed at 10 bits, DEPTH <= 1024
//  NOP_WORD  16'h0000 word returned for out-of-range fetches (PROG_MEM_OOB_NOP_EN only)
// PORTS
//  clk          in   1   single clock, all logic on posedge
//  rst_n        in   1   asynchronous active-low reset
//  load_en      in   1   pulse: begin (re)load of program, any state
//  ld_data      in   16  program word from host
//  ld_vld       in   1   ld_data valid
//  ld_last      in   1   qualifies final word of program (with ld_vld)
//  ld_rdy       out  1   block accepts word when ld_vld & ld_rdy
//  pc           in   10  fetch address from processor
//  ram_read_en  in   1   fetch request, sampled each cycle
//  data_out     out  16  fetched instruction (to processor data_in)
//  data_vld     out  1   data_out valid, one-cycle pulse per fetch
//  start        out  1   one-cycle pulse: program loaded, processor may run
//  prog_len     out  11  number of words loaded (0..DEPTH)
//  load_ovf     out  1   sticky: host offered words beyond DEPTH
// BEHAVIOUR
//  Reset: state=IDLE, ld_rdy=0, data_out=0, data_vld=0, start=0, prog_len=0, load_ovf=0.
//   Storage array is not reset; contents undefined after reset.
//  FSM states IDLE, LOAD, GO, RUN:
//   IDLE -> LOAD on load_en. Any state -> LOAD on load_en (abort; prog_len:=0, load_ovf:=0,
//    data_vld:=0 next cycle, no start pulse until new load completes).
//   LOAD: ld_rdy=1 while prog_len<DEPTH. Accepted word written to mem[prog_len], prog_len++.
//    Accepted word with ld_last=1 -> GO. prog_len reaching DEPTH without ld_last -> GO.
//   GO: ld_rdy=0, start=1 for exactly this one cycle -> RUN.
//   RUN: serves fetches until next load_en or reset. ld_rdy=0.
//  load_ovf: set if ld_vld=1 while in GO/RUN after a load ended at DEPTH without ld_last;
//   word is dropped. ld_vld outside LOAD otherwise ignored silently.
//  Fetch: in RUN, ram_read_en=1 at edge N -> data_out=mem[pc] and data_vld=1 after edge N+1
//   (1-cycle latency). Back-to-back requests give back-to-back data_vld. data_out holds last
//   value when data_vld=0. ram_read_en outside RUN ignored, no data_vld.
//  Out-of-range fetch (pc >= prog_len): see CONFIGURATION.
//  Simultaneous load_en and ram_read_en: load_en wins, fetch dropped.
//  Simultaneous load_en and ld_vld: load_en wins, word dropped (host must wait for ld_rdy).
//  prog_len is 11 bits so DEPTH=1024 is representable; no wrap.
// CONFIGURATION
//  PROG_MEM_OOB_NOP_EN defined: fetch with pc >= prog_len returns NOP_WORD, data_vld=1.
//  Not defined: fetch returns raw mem[pc] (stale/undefined contents), data_vld=1.
// TESTING
//  1 Reset, load_en, 3 words 16'h1111,16'h2222,16'h3333 (ld_last on 3rd) -> prog_len=3,
//    start pulses 1 cycle after 3rd accept, ld_rdy=0 after.
//  2 RUN, ram_read_en=1 pc=1 one cycle -> next cycle data_out=16'h2222, data_vld=1 one cycle;
//    pc=0,1,2 back-to-back -> 1111,2222,3333 on consecutive cycles.
//  3 With PROG_MEM_OOB_NOP_EN, fetch pc=5 after 3-word load -> data_out=NOP_WORD, data_vld=1.
//  4 Load DEPTH=1024 words without ld_last -> prog_len=1024, start pulses, ld_rdy=0;
//    extra ld_vld -> load_ovf=1, mem[0] unchanged.
//  5 load_en in RUN with ram_read_en=1 same cycle -> no data_vld, state LOAD, prog_len=0.
//  6 rst_n low mid-load after 2 words -> all outputs reset values immediately; fetch ignored
//    until new load completes.

Source files
------------

// File: rtl/simple_proc_prog_mem_if.sv
// Program-load handshake between the host and simple_proc_prog_mem.
//   master (host)  : drives ld_data, ld_vld, ld_last; observes ld_rdy
//   slave  (memory): observes ld_data, ld_vld, ld_last; drives ld_rdy
// A word transfers on a clock edge where ld_vld & ld_rdy are both high.
interface simple_proc_prog_mem_if;
  logic [15:0] ld_data;
  logic        ld_vld;
  logic        ld_last;
  logic        ld_rdy;

  modport master (output ld_data, output ld_vld, output ld_last, input ld_rdy);
  modport slave  (input ld_data, input ld_vld, input ld_last, output ld_rdy);
endinterface

// File: rtl/simple_proc_prog_mem.sv
// simple_proc_prog_mem: program memory on the fetch side of simple_proc_data_proc.
// The host streams a program in over the ld handshake; the block stores it,
// pulses start for one cycle, then answers every processor fetch
// (pc + ram_read_en) with the stored word on data_out/data_vld one cycle later.
//
// Optional feature macro: PROG_MEM_OOB_NOP_EN
//   defined     : fetches with pc >= prog_len return NOP_WORD
//   not defined : fetches return raw mem[pc] whatever it holds
//
// Ports:
//   clk, rst_n   clock (posedge) and asynchronous active-low reset
//   load_en      pulse: begin (re)load of the program, valid in any state
//   ld           slave side of the load handshake (ld_data/ld_vld/ld_last/ld_rdy)
//   pc           fetch address from the processor
//   ram_read_en  fetch request, sampled every cycle
//   data_out     fetched word, holds its value while data_vld is low
//   data_vld     one-cycle pulse per served fetch
//   start        one-cycle pulse once a program has been loaded
//   prog_len     number of words loaded (0..DEPTH)
//   load_ovf     sticky: host offered words after a load filled all of DEPTH
module simple_proc_prog_mem #(
  parameter int unsigned DEPTH    = 1024,
  parameter logic [15:0] NOP_WORD = 16'h0000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load_en,
  simple_proc_prog_mem_if.slave       ld,
  input  logic [9:0]                  pc,
  input  logic                        ram_read_en,
  output logic [15:0]                 data_out,
  output logic                        data_vld,
  output logic                        start,
  output logic [10:0]                 prog_len,
  output logic                        load_ovf
);

`ifdef PROG_MEM_OOB_NOP_EN
  localparam bit OOB_NOP = 1'b1;
`else
  localparam bit OOB_NOP = 1'b0;
`endif

  localparam logic [10:0] DEPTH_L = 11'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    GO,
    RUN
  } state_t;

  state_t state, state_next;

  logic [15:0] mem [DEPTH];

  logic        accept;
  logic        last_slot;
  logic        fetch;
  logic        full_end;   // last load filled DEPTH without an ld_last
  logic [15:0] rd_word;

  // Next state, handshake and strobes
  always_comb begin
    state_next = state;
    ld.ld_rdy  = 1'b0;
    start      = 1'b0;
    accept     = 1'b0;
    fetch      = 1'b0;
    last_slot  = (prog_len == DEPTH_L - 11'd1);

    unique case (state)
      IDLE: ;
      LOAD: begin
        ld.ld_rdy = (prog_len < DEPTH_L);
        // load_en restarts the load, so a word offered alongside it is dropped
        accept    = ld.ld_vld & ld.ld_rdy & ~load_en;
        if (accept && (ld.ld_last || last_slot))
          state_next = GO;
      end
      GO: begin
        start      = 1'b1;
        state_next = RUN;
      end
      RUN: fetch = ram_read_en & ~load_en;
      default: state_next = IDLE;
    endcase

    if (load_en)
      state_next = LOAD;
  end

  always_comb begin
    rd_word = mem[pc];
    if (OOB_NOP && ({1'b0, pc} >= prog_len))
      rd_word = NOP_WORD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (accept)
      mem[prog_len[9:0]] <= ld.ld_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prog_len <= '0;
      load_ovf <= 1'b0;
      full_end <= 1'b0;
      data_out <= '0;
      data_vld <= 1'b0;
    end else if (load_en) begin
      prog_len <= '0;
      load_ovf <= 1'b0;
      full_end <= 1'b0;
      data_vld <= 1'b0;
    end else begin
      if (accept) begin
        prog_len <= prog_len + 11'd1;
        if (last_slot && !ld.ld_last)
          full_end <= 1'b1;
      end
      if ((state == GO || state == RUN) && ld.ld_vld && full_end)
        load_ovf <= 1'b1;
      data_vld <= fetch;
      if (fetch)
        data_out <= rd_word;
    end
  end

endmodule

// File: tb/tb_simple_proc_prog_mem.sv
// Directed self-checking bench for simple_proc_prog_mem (DEPTH=1024).
module tb_simple_proc_prog_mem;

  localparam logic [15:0] NOP = 16'hF00D;

  logic        clk;
  logic        rst_n;
  logic        load_en;
  logic [9:0]  pc;
  logic        ram_read_en;
  logic [15:0] data_out;
  logic        data_vld;
  logic        start;
  logic [10:0] prog_len;
  logic        load_ovf;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  simple_proc_prog_mem_if ld_if ();

  simple_proc_prog_mem #(
    .DEPTH    (1024),
    .NOP_WORD (NOP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_en     (load_en),
    .ld          (ld_if),
    .pc          (pc),
    .ram_read_en (ram_read_en),
    .data_out    (data_out),
    .data_vld    (data_vld),
    .start       (start),
    .prog_len    (prog_len),
    .load_ovf    (load_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_load;
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] d, input logic last);
    ld_if.ld_vld  = 1'b1;
    ld_if.ld_data = d;
    ld_if.ld_last = last;
    tick();
    ld_if.ld_vld  = 1'b0;
    ld_if.ld_last = 1'b0;
  endtask

  task automatic fetch(input logic [9:0] a);
    pc          = a;
    ram_read_en = 1'b1;
    tick();
    ram_read_en = 1'b0;
  endtask

  function automatic logic [15:0] word_of(input int i);
    return 16'(i) ^ 16'h5A00;
  endfunction

  initial begin
    rst_n         = 1'b0;
    load_en       = 1'b0;
    pc            = '0;
    ram_read_en   = 1'b0;
    ld_if.ld_vld  = 1'b0;
    ld_if.ld_data = '0;
    ld_if.ld_last = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    check_eq("rst_ld_rdy", 32'(ld_if.ld_rdy), 0);
    check_eq("rst_data_out", 32'(data_out), 0);
    check_eq("rst_data_vld", 32'(data_vld), 0);
    check_eq("rst_start", 32'(start), 0);
    check_eq("rst_prog_len", 32'(prog_len), 0);
    check_eq("rst_load_ovf", 32'(load_ovf), 0);
    rst_n = 1'b1;
    tick();

    // 1: three-word load
    pulse_load();
    check_eq("t1_ld_rdy_load", 32'(ld_if.ld_rdy), 1);
    send_word(16'h1111, 1'b0);
    send_word(16'h2222, 1'b0);
    check_eq("t1_len2", 32'(prog_len), 2);
    check_eq("t1_no_start_yet", 32'(start), 0);
    send_word(16'h3333, 1'b1);
    check_eq("t1_start", 32'(start), 1);
    check_eq("t1_len3", 32'(prog_len), 3);
    check_eq("t1_ld_rdy_go", 32'(ld_if.ld_rdy), 0);
    tick();
    check_eq("t1_start_one_cycle", 32'(start), 0);
    check_eq("t1_ld_rdy_run", 32'(ld_if.ld_rdy), 0);

    // 2: single and back-to-back fetches
    fetch(10'd1);
    check_eq("t2_single_data", 32'(data_out), 32'h2222);
    check_eq("t2_single_vld", 32'(data_vld), 1);
    tick();
    check_eq("t2_vld_drop", 32'(data_vld), 0);
    check_eq("t2_data_hold", 32'(data_out), 32'h2222);
    pc = 10'd0; ram_read_en = 1'b1;
    tick();
    check_eq("t2_b2b_0", 32'(data_out), 32'h1111);
    check_eq("t2_b2b_vld0", 32'(data_vld), 1);
    pc = 10'd1;
    tick();
    check_eq("t2_b2b_1", 32'(data_out), 32'h2222);
    check_eq("t2_b2b_vld1", 32'(data_vld), 1);
    pc = 10'd2;
    tick();
    ram_read_en = 1'b0;
    check_eq("t2_b2b_2", 32'(data_out), 32'h3333);
    check_eq("t2_b2b_vld2", 32'(data_vld), 1);
    tick();
    check_eq("t2_b2b_end", 32'(data_vld), 0);

    // 3: out-of-range fetch
    fetch(10'd5);
    check_eq("t3_oob_vld", 32'(data_vld), 1);
`ifdef PROG_MEM_OOB_NOP_EN
    check_eq("t3_oob_nop", 32'(data_out), 32'(NOP));
`endif
    tick();

    // 5: load_en beats a simultaneous fetch
    load_en = 1'b1; pc = 10'd0; ram_read_en = 1'b1;
    tick();
    load_en = 1'b0; ram_read_en = 1'b0;
    check_eq("t5_no_vld", 32'(data_vld), 0);
    check_eq("t5_len0", 32'(prog_len), 0);
    check_eq("t5_in_load", 32'(ld_if.ld_rdy), 1);
    check_eq("t5_no_start", 32'(start), 0);

    // 4: fill all DEPTH words without ld_last, then overflow
    for (int i = 0; i < 1024; i++) begin
      ld_if.ld_vld  = 1'b1;
      ld_if.ld_data = word_of(i);
      ld_if.ld_last = 1'b0;
      tick();
    end
    check_eq("t4_len_full", 32'(prog_len), 1024);
    check_eq("t4_start", 32'(start), 1);
    check_eq("t4_ld_rdy", 32'(ld_if.ld_rdy), 0);
    check_eq("t4_ovf_clear", 32'(load_ovf), 0);
    ld_if.ld_data = 16'hFFFF;
    tick();
    ld_if.ld_vld = 1'b0;
    check_eq("t4_ovf_set", 32'(load_ovf), 1);
    check_eq("t4_start_off", 32'(start), 0);
    fetch(10'd0);
    check_eq("t4_mem0_kept", 32'(data_out), 32'(word_of(0)));
    fetch(10'd1023);
    check_eq("t4_mem_top", 32'(data_out), 32'(word_of(1023)));
    check_eq("t4_len_stable", 32'(prog_len), 1024);
    tick();
    check_eq("t4_ovf_sticky", 32'(load_ovf), 1);

    // 6: asynchronous reset mid-load
    pulse_load();
    check_eq("t6_ovf_cleared", 32'(load_ovf), 0);
    send_word(16'hC001, 1'b0);
    send_word(16'hC002, 1'b0);
    check_eq("t6_len2", 32'(prog_len), 2);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_len", 32'(prog_len), 0);
    check_eq("t6_rst_ld_rdy", 32'(ld_if.ld_rdy), 0);
    check_eq("t6_rst_data_out", 32'(data_out), 0);
    check_eq("t6_rst_vld", 32'(data_vld), 0);
    check_eq("t6_rst_start", 32'(start), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    fetch(10'd0);
    check_eq("t6_fetch_ignored", 32'(data_vld), 0);
    pulse_load();
    send_word(16'h7777, 1'b1);
    check_eq("t6_reload_start", 32'(start), 1);
    tick();
    fetch(10'd0);
    check_eq("t6_reload_vld", 32'(data_vld), 1);
    check_eq("t6_reload_data", 32'(data_out), 32'h7777);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
